// File: rtl/bresenham_line_engine_if.sv
// Line-draw handshake bundle between the line controller (master) and
// the Bresenham engine (slave). The frame-buffer pix_ready input is
// carried here as well, so the engine has a single bus port.
// Optional macro BLA_PIXEL_COUNT_EN adds the pixel_count signal.
interface bresenham_line_engine_if #(
  parameter int COORD_W = 8
);
  logic               draw_en;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               pix_ready;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               pixel_valid;
  logic               draw_done;
  logic               busy;
`ifdef BLA_PIXEL_COUNT_EN
  logic [COORD_W:0]   pixel_count;

  modport master (
    output draw_en, x0, y0, x1, y1, pix_ready,
    input  pixel_x, pixel_y, pixel_valid, draw_done, busy, pixel_count
  );

  modport slave (
    input  draw_en, x0, y0, x1, y1, pix_ready,
    output pixel_x, pixel_y, pixel_valid, draw_done, busy, pixel_count
  );
`else
  modport master (
    output draw_en, x0, y0, x1, y1, pix_ready,
    input  pixel_x, pixel_y, pixel_valid, draw_done, busy
  );

  modport slave (
    input  draw_en, x0, y0, x1, y1, pix_ready,
    output pixel_x, pixel_y, pixel_valid, draw_done, busy
  );
`endif
endinterface

// File: rtl/bresenham_line_engine.sv
// Integer Bresenham line walker covering all octants. Latches a segment
// when draw_en is seen in IDLE, presents one pixel at a time and advances
// only when the frame buffer accepts it, then pulses draw_done and waits
// for draw_en to drop before it can be re-armed.
// Optional macro BLA_PIXEL_COUNT_EN adds an accepted-pixel counter output.
module bresenham_line_engine #(
  parameter int COORD_W = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  bresenham_line_engine_if.slave  bus
);

  localparam int ERR_W = COORD_W + 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PLOT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_REARM = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [COORD_W-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic signed [COORD_W:0]   dx_q, dx_d, dy_q, dy_d;
  logic                      sx_pos_q, sx_pos_d, sy_pos_q, sy_pos_d;
  logic signed [ERR_W-1:0]   err_q, err_d, err_step;
  logic signed [ERR_W:0]     err2, dx_ext, dy_ext;
  logic [COORD_W-1:0]        abs_dx, abs_dy;
  logic                      plotting;
`ifdef BLA_PIXEL_COUNT_EN
  logic [COORD_W:0]          cnt_q, cnt_d;
`endif

  // Next-state logic: segment latch, setup of the Bresenham terms, and one step per accepted pixel
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_pos_d = sx_pos_q;
    sy_pos_d = sy_pos_q;
    err_d    = err_q;
    err_step = err_q;
`ifdef BLA_PIXEL_COUNT_EN
    cnt_d    = cnt_q;
`endif
    abs_dx   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    abs_dy   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    err2     = $signed({err_q, 1'b0});
    dx_ext   = (ERR_W+1)'(dx_q);
    dy_ext   = (ERR_W+1)'(dy_q);

    case (state_q)
      S_IDLE: begin
        if (bus.draw_en) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          x1_d    = bus.x1;
          y1_d    = bus.y1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dx_d     = $signed({1'b0, abs_dx});
        dy_d     = -$signed({1'b0, abs_dy});
        sx_pos_d = (x0_q < x1_q);
        sy_pos_d = (y0_q < y1_q);
        err_d    = ERR_W'($signed({1'b0, abs_dx})) - ERR_W'($signed({1'b0, abs_dy}));
        cur_x_d  = x0_q;
        cur_y_d  = y0_q;
`ifdef BLA_PIXEL_COUNT_EN
        cnt_d    = '0;
`endif
        state_d  = S_PLOT;
      end
      S_PLOT: begin
        if (!bus.draw_en) begin
          state_d = S_IDLE;
        end else if (bus.pix_ready) begin
`ifdef BLA_PIXEL_COUNT_EN
          cnt_d = cnt_q + (COORD_W+1)'(1);
`endif
          if ((cur_x_q == x1_q) && (cur_y_q == y1_q)) begin
            state_d = S_DONE;
          end else begin
            if (err2 >= dy_ext) begin
              err_step = err_step + ERR_W'(dy_q);
              cur_x_d  = sx_pos_q ? (cur_x_q + COORD_W'(1)) : (cur_x_q - COORD_W'(1));
            end
            if (err2 <= dx_ext) begin
              err_step = err_step + ERR_W'(dx_q);
              cur_y_d  = sy_pos_q ? (cur_y_q + COORD_W'(1)) : (cur_y_q - COORD_W'(1));
            end
            err_d = err_step;
          end
        end
      end
      S_DONE:  state_d = S_REARM;
      S_REARM: if (!bus.draw_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including a line in progress
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_pos_q <= 1'b0;
      sy_pos_q <= 1'b0;
      err_q    <= '0;
`ifdef BLA_PIXEL_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_pos_q <= sx_pos_d;
      sy_pos_q <= sy_pos_d;
      err_q    <= err_d;
`ifdef BLA_PIXEL_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign plotting        = (state_q == S_PLOT);
  assign bus.pixel_valid = plotting;
  assign bus.pixel_x     = plotting ? cur_x_q : '0;
  assign bus.pixel_y     = plotting ? cur_y_q : '0;
  assign bus.draw_done   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
`ifdef BLA_PIXEL_COUNT_EN
  assign bus.pixel_count = cnt_q;
`endif

endmodule
